// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - funct codes of the HI/LO instruction group
//   - R-type ALUOp encoding
//   - FSM state encoding (IDLE/BUSY/DONE)
//   - default operand width
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] ALUOP_R = 2'b10;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // MULT/MULTU/DIV/DIVU occupy 6'h18..6'h1B: common prefix 4'b0110.
    // Within the group, funct[1] selects divide and funct[0] selects unsigned.
    function automatic logic is_muldiv(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bundle between the ID/EX stage register / hazard logic and the mul/div unit.
//   ALUOp_in, funct_in   : decoded instruction in EX
//   op_a_in, op_b_in     : forwarded rs / rt values
//   flush_in             : kill the instruction in EX
//   muldiv_stall         : hold PC, IF/ID, ID/EX; bubble into EX/MEM
//   busy_out             : unit FSM not idle
//   hi_out, lo_out       : architectural HI/LO
//   mf_result_out        : MFHI/MFLO read data
// master = pipeline side, slave = mul/div unit side.
interface muldiv_if #(
    parameter int WIDTH = muldiv_pkg::WIDTH_DEF
);
    logic [1:0]       ALUOp_in;
    logic [5:0]       funct_in;
    logic [WIDTH-1:0] op_a_in;
    logic [WIDTH-1:0] op_b_in;
    logic             flush_in;
    logic             muldiv_stall;
    logic             busy_out;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] mf_result_out;

    modport master (
        output ALUOp_in, funct_in, op_a_in, op_b_in, flush_in,
        input  muldiv_stall, busy_out, hi_out, lo_out, mf_result_out
    );

    modport slave (
        input  ALUOp_in, funct_in, op_a_in, op_b_in, flush_in,
        output muldiv_stall, busy_out, hi_out, lo_out, mf_result_out
    );

endinterface

// File: rtl/muldiv_core.sv
// Iterative radix-2 multiply / restoring-divide datapath.
//   clk, rst       : clock, synchronous active-high reset (control only)
//   start          : latch operands and begin WIDTH iterations
//   abort          : drop the operation in progress
//   is_div         : 1 = divide, 0 = multiply
//   is_signed      : 1 = signed operands (MULT/DIV)
//   op_a, op_b     : multiplicand/dividend, multiplier/divisor
//   done           : high during the last iteration cycle; res_hi/res_lo valid
//   res_hi, res_lo : sign-corrected result (HI/LO layout)
module muldiv_core import muldiv_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    logic             busy;
    logic [CNT_W-1:0] cnt;

    // acc: product upper half (mul) / partial remainder (div)
    // sh : multiplier shifting out + product lower half (mul) / dividend shifting out + quotient (div)
    // m  : multiplicand magnitude (mul) / divisor magnitude (div)
    logic [WIDTH-1:0] acc, sh, m, a_raw;
    logic             mode_div, neg_q, neg_r, div0;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_fits;
    logic [WIDTH-1:0]   acc_nx, sh_nx;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, m} : '0);
        div_shift = {acc, sh[WIDTH-1]};
        div_fits  = div_shift >= {1'b0, m};
        if (mode_div) begin
            // Remainder after a successful subtract is below the divisor, so it fits WIDTH bits.
            acc_nx = div_fits ? WIDTH'(div_shift - {1'b0, m}) : div_shift[WIDTH-1:0];
            sh_nx  = {sh[WIDTH-2:0], div_fits};
        end else begin
            acc_nx = mul_sum[WIDTH:1];
            sh_nx  = {mul_sum[0], sh[WIDTH-1:1]};
        end
    end

    // Results are taken from the next-state values so HI/LO can be written
    // on the same edge that completes the final iteration.
    always_comb begin
        prod = cond_neg_2w({acc_nx, sh_nx}, neg_q);
        if (mode_div) begin
            if (div0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = cond_neg_w(acc_nx, neg_r);
                res_lo = cond_neg_w(sh_nx, neg_q);
            end
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    assign done = busy && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mode_div <= is_div;
            a_raw    <= op_a;
            div0     <= (op_b == '0);
            neg_q    <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r    <= is_signed && op_a[WIDTH-1];
            acc      <= '0;
            if (is_div) begin
                sh <= magnitude(op_a, is_signed);
                m  <= magnitude(op_b, is_signed);
            end else begin
                sh <= magnitude(op_b, is_signed);
                m  <= magnitude(op_a, is_signed);
            end
        end else if (busy) begin
            acc <= acc_nx;
            sh  <= sh_nx;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, the IDLE/BUSY/DONE sequencer
// and the pipeline stall; the iterative arithmetic lives in muldiv_core.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : muldiv_if.slave (instruction, operands, flush in; stall, busy,
//         HI/LO and MFHI/MFLO data out)
module ex_muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);

    state_t           state, state_nx;
    logic             r_type, start_req;
    logic             stall, core_start, core_abort, core_done;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] hi, lo, mf;

    // A flushed instruction is treated as absent.
    assign r_type    = (bus.ALUOp_in == ALUOP_R) && !bus.flush_in;
    assign start_req = r_type && is_muldiv(bus.funct_in);

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .abort     (core_abort),
        .is_div    (bus.funct_in[1]),
        .is_signed (~bus.funct_in[0]),
        .op_a      (bus.op_a_in),
        .op_b      (bus.op_b_in),
        .done      (core_done),
        .res_hi    (core_hi),
        .res_lo    (core_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        stall      = 1'b0;
        core_start = 1'b0;
        core_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    stall      = 1'b1;
                    core_start = 1'b1;
                    state_nx   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.flush_in) begin
                    core_abort = 1'b1;
                    state_nx   = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    if (core_done) state_nx = ST_DONE;
                end
            end
            // One unstalled cycle lets the instruction leave EX; never restart on it.
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_BUSY) begin
            if (core_done && !bus.flush_in) begin
                hi <= core_hi;
                lo <= core_lo;
            end
        end else if (state == ST_IDLE && r_type) begin
            if (bus.funct_in == F_MTHI) hi <= bus.op_a_in;
            if (bus.funct_in == F_MTLO) lo <= bus.op_a_in;
        end
    end

    always_comb begin
        mf = '0;
        if (!rst && r_type) begin
            if (bus.funct_in == F_MFHI) mf = hi;
            if (bus.funct_in == F_MFLO) mf = lo;
        end
    end

    assign bus.muldiv_stall  = stall;
    assign bus.busy_out      = (state != ST_IDLE);
    assign bus.hi_out        = hi;
    assign bus.lo_out        = lo;
    assign bus.mf_result_out = mf;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases with literal
// expectations, then randomized instruction streams compared every cycle
// against an instruction-level reference model.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = no op in flight, 1..32 = k-th iterating cycle, 33 = completion cycle
    int          phase = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi, p_lo;

    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] up;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        hi = '0; lo = '0;
        case (f)
            F_MULT:  begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
            F_MULTU: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
            F_DIV: begin
                if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            F_DIVU: begin
                if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
    endfunction

    function automatic bit present();
        return (bus.ALUOp_in == ALUOP_R) && !bus.flush_in;
    endfunction

    function automatic bit is_md_f(input logic [5:0] f);
        return f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            phase = 0; m_hi = '0; m_lo = '0;
        end else if (phase == 0) begin
            if (present() && is_md_f(bus.funct_in)) begin
                phase = 1;
                ref_op(bus.funct_in, bus.op_a_in, bus.op_b_in, p_hi, p_lo);
            end else if (present() && bus.funct_in == F_MTHI) m_hi = bus.op_a_in;
            else if (present() && bus.funct_in == F_MTLO) m_lo = bus.op_a_in;
        end else if (phase <= 32) begin
            if (bus.flush_in) phase = 0;
            else begin
                if (phase == 32) begin m_hi = p_hi; m_lo = p_lo; end
                phase++;
            end
        end else begin
            phase = 0;
        end
    end

    always @(negedge clk) begin
        logic        e_stall, e_busy;
        logic [31:0] e_mf;
        if (chk_en) begin
            e_stall = (phase == 0 && present() && is_md_f(bus.funct_in)) ||
                      (phase >= 1 && phase <= 32 && !bus.flush_in);
            e_busy  = (phase != 0);
            e_mf    = '0;
            if (!rst && present() && bus.funct_in == F_MFHI) e_mf = m_hi;
            if (!rst && present() && bus.funct_in == F_MFLO) e_mf = m_lo;
            check("cyc_stall", bus.muldiv_stall, e_stall);
            check("cyc_busy",  bus.busy_out,     e_busy);
            check("cyc_hi",    bus.hi_out,       m_hi);
            check("cyc_lo",    bus.lo_out,       m_lo);
            check("cyc_mf",    bus.mf_result_out, e_mf);
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int rst_at, input logic [1:0] aop,
                         output int n, output logic [31:0] mf);
        bit fin;
        bus.ALUOp_in = aop;
        bus.funct_in = f;
        bus.op_a_in  = a;
        bus.op_b_in  = b;
        bus.flush_in = 1'b0;
        n = 0; mf = '0; fin = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (flush_at >= 0 && n == flush_at) bus.flush_in = 1'b1;
            if (rst_at >= 0 && n == rst_at) rst = 1'b1;
            @(negedge clk);
            if (c == 0) mf = bus.mf_result_out;
            if (rst) begin
                @(posedge clk); #1; rst = 1'b0; fin = 1'b1; break;
            end
            if (!bus.muldiv_stall) begin
                @(posedge clk); #1; fin = 1'b1; break;
            end
            n++;
            @(posedge clk); #1;
        end
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL op_timeout: stall still 1 after 80 cycles, required release");
        end
        bus.ALUOp_in = 2'b00;
        bus.funct_in = 6'h00;
        bus.flush_in = 1'b0;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n;
        logic [31:0] mf;
        logic [5:0]  fset [9];
        fset = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO, 6'h20};

        bus.ALUOp_in = 2'b00; bus.funct_in = 6'h00;
        bus.op_a_in = '0; bus.op_b_in = '0; bus.flush_in = 1'b0;

        // reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi",    bus.hi_out, 32'h0);
        check("rst_lo",    bus.lo_out, 32'h0);
        check("rst_stall", bus.muldiv_stall, 1'b0);
        check("rst_busy",  bus.busy_out, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        // unsigned extreme product
        do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, ALUOP_R, n, mf);
        check("multu_stalls", n, 33);
        check("multu_hi", bus.hi_out, 32'hFFFFFFFE);
        check("multu_lo", bus.lo_out, 32'h00000001);
        check("model_multu_lo", m_lo, 32'h00000001);

        do_op(F_MULT, -32'sd7, 32'd3, -1, -1, ALUOP_R, n, mf);
        check("mult_hi", bus.hi_out, 32'hFFFFFFFF);
        check("mult_lo", bus.lo_out, 32'hFFFFFFEB);

        do_op(F_DIV, -32'sd7, 32'd2, -1, -1, ALUOP_R, n, mf);
        check("div_lo", bus.lo_out, 32'hFFFFFFFD);
        check("div_hi", bus.hi_out, 32'hFFFFFFFF);
        check("model_div_lo", m_lo, 32'hFFFFFFFD);

        do_op(F_DIVU, 32'd100, 32'd0, -1, -1, ALUOP_R, n, mf);
        check("divu0_stalls", n, 33);
        check("divu0_lo", bus.lo_out, 32'hFFFFFFFF);
        check("divu0_hi", bus.hi_out, 32'd100);

        do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, ALUOP_R, n, mf);
        check("divmin_lo", bus.lo_out, 32'h80000000);
        check("divmin_hi", bus.hi_out, 32'h0);

        // move-to then move-from on the next cycle
        do_op(F_MTHI, 32'h1234, 32'h0, -1, -1, ALUOP_R, n, mf);
        check("mthi_stalls", n, 0);
        do_op(F_MFHI, 32'h0, 32'h0, -1, -1, ALUOP_R, n, mf);
        check("mfhi_val", mf, 32'h1234);
        check("mfhi_stalls", n, 0);

        // flush mid-iteration, then a clean run, then reset mid-iteration
        do_op(F_MTLO, 32'h55, 32'h0, -1, -1, ALUOP_R, n, mf);
        do_op(F_MTHI, 32'h66, 32'h0, -1, -1, ALUOP_R, n, mf);
        do_op(F_MULT, 32'd3, 32'd4, 10, -1, ALUOP_R, n, mf);
        check("flush_stalls", n, 10);
        check("flush_hi", bus.hi_out, 32'h66);
        check("flush_lo", bus.lo_out, 32'h55);
        do_op(F_MULT, 32'd5, 32'd6, -1, -1, ALUOP_R, n, mf);
        check("after_flush_stalls", n, 33);
        check("after_flush_hi", bus.hi_out, 32'h0);
        check("after_flush_lo", bus.lo_out, 32'd30);
        do_op(F_MULT, 32'd9, 32'd9, -1, 5, ALUOP_R, n, mf);
        check("rst_mid_hi", bus.hi_out, 32'h0);
        check("rst_mid_lo", bus.lo_out, 32'h0);
        check("rst_mid_busy", bus.busy_out, 1'b0);

        // flushed MTHI must not write; non-R-type MULT must not start
        do_op(F_MTHI, 32'hDEAD, 32'h0, 0, -1, ALUOP_R, n, mf);
        check("flush_mthi_hi", bus.hi_out, 32'h0);
        do_op(F_MULT, 32'd2, 32'd2, -1, -1, 2'b00, n, mf);
        check("nonr_stalls", n, 0);

        // randomized stream
        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            logic [1:0] aop;
            int fa;
            f   = fset[$urandom_range(0, 8)];
            aop = ($urandom_range(0, 7) == 0) ? 2'b01 : ALUOP_R;
            fa  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 33)) : -1;
            do_op(f, rand_val(), rand_val(), fa, -1, aop, n, mf);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
